fetch_unit: RTL and testbench

Instruction fetch stage that sits directly upstream of the instruction queue. It generates sequential PCs and issues one-outstanding requests to the instruction memory. Each returned word is placed, tagged with its PC, into a single-entry output buffer, and that buffer is pushed into the queue with its enque/halt handshake. On a flush it drops all in-flight state, including a memory response still pending, and restarts at a redirect PC.

---
 rtl/fetch_unit.sv | 112 +++++++++++
 tb/tb_fetch_unit.sv | 369 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: sequential instruction fetch with a single outstanding memory
// request and a one-entry {pc, instr} output buffer feeding the instruction
// queue. A flush drops everything, including a response still in flight,
// and restarts fetching at the redirect address.
module fetch_unit #(
   parameter int                    ADDR_WIDTH  = 32,
   parameter int                    INSTR_WIDTH = 32,
   parameter logic [ADDR_WIDTH-1:0] RESET_PC    = 32'hBFC00000
) (
   input  logic                              clk,
   input  logic                              reset,
   input  logic                              stall,
   input  logic                              flush,
   input  logic [ADDR_WIDTH-1:0]             redirect_pc,
   output logic                              imem_req,
   output logic [ADDR_WIDTH-1:0]             imem_addr,
   input  logic                              imem_ack,
   input  logic [INSTR_WIDTH-1:0]            imem_data,
   input  logic                              q_halt,
   output logic                              enque,
   output logic [ADDR_WIDTH+INSTR_WIDTH-1:0] enque_data
);

   typedef enum logic [1:0] {
      FETCH    = 2'd0,
      WAIT_BUF = 2'd1,
      DISCARD  = 2'd2
   } state_t;

   state_t                              state_q, state_d;
   logic [ADDR_WIDTH-1:0]               pc_q, pc_d;
   // Address of the request that is still in flight while discarding; pc
   // already holds the redirect target at that point.
   logic [ADDR_WIDTH-1:0]               disc_addr_q, disc_addr_d;
   logic                                out_valid_q, out_valid_d;
   logic [ADDR_WIDTH+INSTR_WIDTH-1:0]   out_buf_q, out_buf_d;

   // Redirect targets are forced to word alignment, so the low bits never matter.
   logic unused_redirect_lsb;
   assign unused_redirect_lsb = ^redirect_pc[1:0];

   // Queue push only when the queue can take it, so every push is accepted.
   assign enque      = out_valid_q & ~q_halt & ~stall & ~flush;
   assign enque_data = out_buf_q;
   assign imem_req   = (state_q == FETCH) | (state_q == DISCARD);
   assign imem_addr  = (state_q == DISCARD) ? disc_addr_q : pc_q;

   // Next-state logic: flush overrides normal sequencing; acks outside a
   // request (WAIT_BUF) fall through the case untouched.
   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      disc_addr_d = disc_addr_q;
      out_valid_d = out_valid_q;
      out_buf_d   = out_buf_q;
      if (flush) begin
         out_valid_d = 1'b0;
         out_buf_d   = '0;
         pc_d        = {redirect_pc[ADDR_WIDTH-1:2], 2'b00};
         if ((state_q == FETCH || state_q == DISCARD) && !imem_ack) begin
            state_d = DISCARD;
         end else begin
            state_d = FETCH;
         end
         // Keep driving the abandoned request's address until it completes.
         if (state_q == FETCH && !imem_ack) begin
            disc_addr_d = pc_q;
         end
      end else begin
         case (state_q)
            FETCH: begin
               if (imem_ack) begin
                  out_buf_d   = {pc_q, imem_data};
                  out_valid_d = 1'b1;
                  pc_d        = pc_q + ADDR_WIDTH'(4);
                  state_d     = WAIT_BUF;
               end
            end
            WAIT_BUF: begin
               if (enque) begin
                  out_valid_d = 1'b0;
                  state_d     = FETCH;
               end
            end
            DISCARD: begin
               if (imem_ack) begin
                  state_d = FETCH;
               end
            end
            default: state_d = FETCH;
         endcase
      end
   end

   // State registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= FETCH;
         pc_q        <= RESET_PC;
         disc_addr_q <= '0;
         out_valid_q <= 1'b0;
         out_buf_q   <= '0;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         disc_addr_q <= disc_addr_d;
         out_valid_q <= out_valid_d;
         out_buf_q   <= out_buf_d;
      end
   end

endmodule

// File: tb/tb_fetch_unit.sv
// Testbench for fetch_unit: a behavioural instruction memory returning
// addr^1 with programmable latency, directed timing scenarios, and a
// randomized run checked against an in-order expected-PC stream.
module tb_fetch_unit;
   localparam logic [31:0] RPC = 32'hBFC00000;

   logic        clk = 1'b0;
   logic        reset = 1'b1, stall = 1'b0, flush = 1'b0, q_halt = 1'b0;
   logic [31:0] redirect_pc = '0;
   logic        imem_req, imem_ack = 1'b0;
   logic [31:0] imem_addr, imem_data = '0;
   logic        enque;
   logic [63:0] enque_data;

   int errors = 0;
   int checks = 0;
   int lat = 0;
   int mem_cnt = 0;
   logic spur_ack = 1'b0;

   fetch_unit dut (
      .clk(clk), .reset(reset), .stall(stall), .flush(flush),
      .redirect_pc(redirect_pc), .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_ack(imem_ack), .imem_data(imem_data), .q_halt(q_halt),
      .enque(enque), .enque_data(enque_data)
   );

   always #5 clk = ~clk;

   // Memory: answers a request after `lat` waiting cycles (0 = same cycle);
   // spur_ack injects an ack with junk data while no request is up.
   always @(negedge clk) begin
      if (reset) begin
         mem_cnt = 0;
         imem_ack = 1'b0;
      end else if (imem_req) begin
         if (mem_cnt >= lat) begin
            imem_ack = 1'b1;
            imem_data = imem_addr ^ 32'h1;
            mem_cnt = 0;
         end else begin
            imem_ack = 1'b0;
            mem_cnt++;
         end
      end else begin
         imem_ack = spur_ack;
         imem_data = $urandom;
         mem_cnt = 0;
      end
   end

   task automatic step_cyc();
      @(posedge clk); #1;
   endtask

   task automatic sample();
      @(negedge clk); #1;
   endtask

   task automatic do_reset();
      reset = 1'b1; stall = 1'b0; flush = 1'b0; q_halt = 1'b0; spur_ack = 1'b0;
      step_cyc(); step_cyc();
      reset = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      step_cyc();
      sample();
      checks++;
      if (enque !== 1'b0 || enque_data !== 64'h0) begin
         errors++; $display("FAIL reset_outbuf: enque=%b data=%h want 0/0", enque, enque_data);
      end
      checks++;
      if (imem_req !== 1'b1 || imem_addr !== RPC) begin
         errors++; $display("FAIL reset_req: req=%b addr=%h want 1/%h", imem_req, imem_addr, RPC);
      end
   endtask

   task automatic test_zero_latency();
      logic [31:0] p;
      lat = 0;
      do_reset();
      for (int k = 0; k < 8; k++) begin
         sample();
         p = RPC + 32'(4 * (k / 2));
         checks++;
         if (enque !== ((k % 2) == 1)) begin
            errors++; $display("FAIL zl_enque cyc%0d: got %b want %b", k, enque, (k % 2) == 1);
         end
         if (k % 2 == 1) begin
            checks++;
            if (enque_data !== {p, p ^ 32'h1}) begin
               errors++; $display("FAIL zl_data cyc%0d: got %h want %h", k, enque_data, {p, p ^ 32'h1});
            end
         end else begin
            checks++;
            if (imem_req !== 1'b1 || imem_addr !== p) begin
               errors++; $display("FAIL zl_req cyc%0d: req=%b addr=%h want 1/%h", k, imem_req, imem_addr, p);
            end
         end
         step_cyc();
      end
   endtask

   task automatic test_halt();
      lat = 0;
      do_reset();
      step_cyc();
      q_halt = 1'b1;
      for (int i = 0; i < 5; i++) begin
         sample();
         checks++;
         if (enque !== 1'b0 || enque_data !== {RPC, RPC ^ 32'h1} || imem_req !== 1'b0) begin
            errors++; $display("FAIL halt_hold %0d: enque=%b data=%h req=%b", i, enque, enque_data, imem_req);
         end
         step_cyc();
      end
      q_halt = 1'b0;
      sample();
      checks++;
      if (enque !== 1'b1 || enque_data !== {RPC, RPC ^ 32'h1}) begin
         errors++; $display("FAIL halt_release: enque=%b data=%h", enque, enque_data);
      end
      step_cyc();
      sample();
      checks++;
      if (enque !== 1'b0 || imem_req !== 1'b1 || imem_addr !== RPC + 32'd4) begin
         errors++; $display("FAIL halt_resume: enque=%b req=%b addr=%h want 0/1/%h", enque, imem_req, imem_addr, RPC + 32'd4);
      end
      step_cyc();
      sample();
      checks++;
      if (enque !== 1'b1 || enque_data !== {RPC + 32'd4, (RPC + 32'd4) ^ 32'h1}) begin
         errors++; $display("FAIL halt_next: enque=%b data=%h", enque, enque_data);
      end
      step_cyc();
   endtask

   task automatic test_flush_pending();
      logic got;
      lat = 3;
      do_reset();
      step_cyc();
      flush = 1'b1; redirect_pc = 32'h00400010;
      sample();
      checks++;
      if (enque !== 1'b0 || imem_req !== 1'b1 || imem_addr !== RPC) begin
         errors++; $display("FAIL fp_flushcyc: enque=%b req=%b addr=%h", enque, imem_req, imem_addr);
      end
      step_cyc();
      flush = 1'b0;
      for (int i = 0; i < 2; i++) begin
         sample();
         checks++;
         if (imem_req !== 1'b1 || imem_addr !== RPC || enque !== 1'b0) begin
            errors++; $display("FAIL fp_discard %0d: req=%b addr=%h enque=%b want 1/%h/0", i, imem_req, imem_addr, enque, RPC);
         end
         step_cyc();
      end
      sample();
      checks++;
      if (imem_req !== 1'b1 || imem_addr !== 32'h00400010) begin
         errors++; $display("FAIL fp_redirect: req=%b addr=%h want 1/00400010", imem_req, imem_addr);
      end
      got = 1'b0;
      for (int i = 0; i < 20 && !got; i++) begin
         sample();
         if (enque === 1'b1) begin
            got = 1'b1;
            checks++;
            if (enque_data !== {32'h00400010, 32'h00400011}) begin
               errors++; $display("FAIL fp_first_enque: got %h want 0040001000400011", enque_data);
            end
         end
         step_cyc();
      end
      checks++;
      if (!got) begin
         errors++; $display("FAIL fp_timeout: no enque within 20 cycles");
      end
   endtask

   task automatic test_flush_ack();
      lat = 0;
      do_reset();
      step_cyc();
      flush = 1'b1; redirect_pc = 32'h00400020; spur_ack = 1'b1;
      sample();
      checks++;
      if (enque !== 1'b0) begin
         errors++; $display("FAIL fa_enque: got %b want 0", enque);
      end
      step_cyc();
      flush = 1'b0; spur_ack = 1'b0;
      sample();
      checks++;
      if (imem_req !== 1'b1 || imem_addr !== 32'h00400020 || enque !== 1'b0) begin
         errors++; $display("FAIL fa_redirect: req=%b addr=%h enque=%b", imem_req, imem_addr, enque);
      end
      step_cyc();
      sample();
      checks++;
      if (enque !== 1'b1 || enque_data !== {32'h00400020, 32'h00400021}) begin
         errors++; $display("FAIL fa_word: enque=%b data=%h", enque, enque_data);
      end
      step_cyc();
      // Flush in the same cycle as a genuine ack: that word is dropped too.
      flush = 1'b1; redirect_pc = 32'h00400100;
      sample();
      checks++;
      if (enque !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h00400024) begin
         errors++; $display("FAIL fa_ackflush: enque=%b req=%b addr=%h", enque, imem_req, imem_addr);
      end
      step_cyc();
      flush = 1'b0;
      sample();
      checks++;
      if (enque !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h00400100) begin
         errors++; $display("FAIL fa_dropped: enque=%b req=%b addr=%h", enque, imem_req, imem_addr);
      end
      step_cyc();
      sample();
      checks++;
      if (enque !== 1'b1 || enque_data !== {32'h00400100, 32'h00400101}) begin
         errors++; $display("FAIL fa_after: enque=%b data=%h", enque, enque_data);
      end
      step_cyc();
   endtask

   task automatic test_wrap();
      logic [31:0] exp_q[$];
      logic [31:0] p;
      exp_q = '{32'hFFFFFFF8, 32'hFFFFFFFC, 32'h00000000};
      lat = 0;
      do_reset();
      step_cyc();
      flush = 1'b1; redirect_pc = 32'hFFFFFFF8;
      step_cyc();
      flush = 1'b0;
      for (int i = 0; i < 12 && exp_q.size() > 0; i++) begin
         sample();
         if (enque === 1'b1) begin
            p = exp_q.pop_front();
            checks++;
            if (enque_data !== {p, p ^ 32'h1}) begin
               errors++; $display("FAIL wrap_word: got %h want %h", enque_data, {p, p ^ 32'h1});
            end
         end
         step_cyc();
      end
      checks++;
      if (exp_q.size() != 0) begin
         errors++; $display("FAIL wrap_count: %0d words missing", exp_q.size());
      end
   endtask

   task automatic test_misalign_reset();
      logic got;
      lat = 0;
      do_reset();
      step_cyc();
      flush = 1'b1; redirect_pc = 32'h00400013;
      step_cyc();
      flush = 1'b0;
      sample();
      checks++;
      if (imem_req !== 1'b1 || imem_addr !== 32'h00400010) begin
         errors++; $display("FAIL misalign: req=%b addr=%h want 1/00400010", imem_req, imem_addr);
      end
      // Reset while discarding.
      lat = 5;
      do_reset();
      flush = 1'b1; redirect_pc = 32'h00500000;
      step_cyc();
      flush = 1'b0;
      sample();
      checks++;
      if (imem_req !== 1'b1 || imem_addr !== RPC) begin
         errors++; $display("FAIL rd_discard: req=%b addr=%h", imem_req, imem_addr);
      end
      step_cyc();
      reset = 1'b1;
      step_cyc();
      reset = 1'b0;
      sample();
      checks++;
      if (imem_req !== 1'b1 || imem_addr !== RPC) begin
         errors++; $display("FAIL rd_restart: req=%b addr=%h want 1/%h", imem_req, imem_addr, RPC);
      end
      got = 1'b0;
      for (int i = 0; i < 20 && !got; i++) begin
         sample();
         if (enque === 1'b1) begin
            got = 1'b1;
            checks++;
            if (enque_data !== {RPC, RPC ^ 32'h1}) begin
               errors++; $display("FAIL rd_first: got %h want %h", enque_data, {RPC, RPC ^ 32'h1});
            end
         end
         step_cyc();
      end
      checks++;
      if (!got) begin
         errors++; $display("FAIL rd_timeout: no enque within 20 cycles");
      end
   endtask

   // Random stall/halt/flush/latency; the reference is simply the ordered
   // PC stream: each accepted word must be the next word-address after the
   // previous one (or the aligned redirect after a flush), tagged with addr^1.
   task automatic test_random();
      logic [31:0] exp_pc;
      logic        prev_req, prev_ack;
      logic [31:0] prev_addr;
      int          enq_cnt;
      lat = 0;
      do_reset();
      exp_pc = RPC; prev_req = 1'b0; prev_ack = 1'b0; prev_addr = '0; enq_cnt = 0;
      for (int c = 0; c < 1500; c++) begin
         lat = $urandom_range(0, 3);
         stall = ($urandom_range(0, 99) < 25);
         q_halt = ($urandom_range(0, 99) < 25);
         flush = ($urandom_range(0, 99) < 6);
         redirect_pc = $urandom;
         spur_ack = ($urandom_range(0, 99) < 20);
         sample();
         if (prev_req && !prev_ack) begin
            checks++;
            if (imem_req !== 1'b1 || imem_addr !== prev_addr) begin
               errors++; $display("FAIL rnd_stable cyc%0d: req=%b addr=%h want 1/%h", c, imem_req, imem_addr, prev_addr);
            end
         end
         checks++;
         if ((enque & (q_halt | stall | flush)) !== 1'b0) begin
            errors++; $display("FAIL rnd_enque_gate cyc%0d: enque=%b halt=%b stall=%b flush=%b", c, enque, q_halt, stall, flush);
         end
         if (enque === 1'b1) begin
            enq_cnt++;
            checks++;
            if (enque_data !== {exp_pc, exp_pc ^ 32'h1}) begin
               errors++; $display("FAIL rnd_word cyc%0d: got %h want %h", c, enque_data, {exp_pc, exp_pc ^ 32'h1});
            end
            exp_pc = exp_pc + 32'd4;
         end
         if (flush) exp_pc = {redirect_pc[31:2], 2'b00};
         prev_req = imem_req; prev_ack = imem_ack; prev_addr = imem_addr;
         step_cyc();
      end
      stall = 1'b0; q_halt = 1'b0; flush = 1'b0; spur_ack = 1'b0;
      checks++;
      if (enq_cnt < 40) begin
         errors++; $display("FAIL rnd_progress: only %0d words enqueued", enq_cnt);
      end
   endtask

   initial begin
      test_reset();
      test_zero_latency();
      test_halt();
      test_flush_pending();
      test_flush_ack();
      test_wrap();
      test_misalign_reset();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
